fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the araucaria 5-stage pipeline. It owns the program counter, issues addresses to the synchronous instruction ROM, and presents the fetched instruction and its PC to the decoder through a registered IF/ID boundary with a valid bit. It accepts stall requests from decode hazard logic and jump or branch redirects resolved in EX, and squashes the wrong-path instruction in flight.

## Interface
Parameters:
- PC_W, 10, program-counter and ROM address width
- INSTR_W, 16, instruction width
- OFF_W, 6, branch offset width (two's complement)

Ports:
- Clock  in  1  single clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- oRomAddr  out  PC_W  address sampled by the ROM at the next rising edge
- iRomInstr  in  INSTR_W  ROM data for the address sampled at the previous edge
- iStall  in  1  hold the PC and the IF/ID register
- iJmpEnable  in  1  absolute jump taken this cycle
- iJmpDir  in  PC_W  jump target
- iBranchTaken  in  1  conditional branch taken this cycle
- iBranchPC  in  PC_W  PC of the branch instruction
- iBranchDir  in  OFF_W  signed branch offset
- oInstr  out  INSTR_W  IF/ID instruction
- oPC  out  PC_W  IF/ID instruction address
- oValid  out  1  IF/ID holds a real instruction
- oKill  out  1  combinational redirect indication, used downstream to squash ID/EX

## Operation
- Internal registers:
  - fpc: next address to issue.
  - reqPC: address currently in flight.
  - reqValid: an in-flight request is real.
  - FSM: BOOT, RUN, HOLD.
- Redirect is `iJmpEnable | iBranchTaken`.
- Target selection:
  - Jump has priority when both are set: target = iJmpDir.
  - Branch: target = iBranchPC + 1 + sext(iBranchDir), modulo 2^PC_W.
- oRomAddr selection, in priority order:
  - redirect: target
  - else if iStall: reqPC, so the ROM re-reads the held instruction
  - else: fpc
- Redirect overrides stall. On a redirect edge:
  - fpc <= target+1, reqPC <= target, reqValid <= 1.
  - IF/ID: oValid <= 0 and oInstr <= NOP (16'h0000).
  - FSM -> RUN.
- FSM transitions:
  - BOOT: entered on Reset; reqValid = 0. The next edge issues address 0 and moves to RUN, or to HOLD if iStall is set.
  - RUN, with no stall and no redirect: IF/ID <= {iRomInstr, reqPC, reqValid}; reqPC <= fpc; fpc <= fpc+1; reqValid <= 1.
  - RUN with iStall -> HOLD: IF/ID, fpc, reqPC and reqValid are all held.
  - HOLD with iStall: stays in HOLD. HOLD without iStall: behaves as RUN and returns to RUN.
- The PC wraps from 10'h3FF to 10'h000 silently.
- Reset mid-operation discards the in-flight request and any pending redirect.

## Timing
- Reset values:
  - oPC = 0, oInstr = 16'h0000, oValid = 0, oKill = 0.
  - oRomAddr = 0, fpc = 0, reqPC = 0, reqValid = 0, FSM = BOOT.
- Fetch latency:
  - Address issued in cycle c appears on oInstr/oPC/oValid after the edge ending cycle c+1.
  - With Reset deasserted before edge 0: edge 0 samples address 0 and edge 1 presents PC 0 with oValid=1.
  - Steady state is one instruction per cycle.
- Redirect penalty:
  - Redirect asserted in cycle c: oValid=0 after edge c, then the target instruction is valid after edge c+1.
  - One bubble from the fetch side. oKill is high during cycle c only.
- Stall: while iStall=1 the outputs are frozen; release resumes with no lost or duplicated instruction.

## Configuration
- FETCH_PERF_EN defined adds two outputs:
  - oFetchCount (16 bits): increments on every edge that loads IF/ID with oValid=1; saturates at 16'hFFFF.
  - oSquashCount (8 bits): increments per redirect; saturates at 8'hFF.
  - Both counters reset to 0.
- FETCH_PERF_EN undefined: both ports and both counters are absent; all other behaviour is identical.

## Structure
- Shared definitions file `def.v`:
  - PC_W, INSTR_W, OFF_W defaults.
  - NOP encoding 16'h0000.
  - FSM state encodings: BOOT=2'd0, RUN=2'd1, HOLD=2'd2.
- Sub-module `pc_target` (combinational): jump/branch priority and sign-extended target arithmetic.
- All pipeline registers use the existing FFD.

## Test plan
- Reset release with a ROM preloaded with mem[i]=16'h1000+i: after edge 1, oPC=0, oInstr=16'h1000, oValid=1; then oPC increments by 1 per cycle.
- iStall high for 3 cycles while oPC=5: oPC stays 5 and oInstr stays 16'h1005 for 3 cycles; after release the sequence is 6, 7 with no gaps or repeats.
- iJmpEnable with iJmpDir=10'h200 in cycle c: oKill=1 in cycle c, oValid=0 after edge c, then oPC=10'h200 and oInstr=16'h1200 after edge c+1.
- Branch with iBranchPC=10'h010 and iBranchDir=6'b111100 (-4): target 10'h00D; the same bubble pattern as the jump case.
- Jump, branch and stall asserted together with iJmpDir=10'h050 and branch target 10'h020: the fetch goes to 10'h050, the stall is ignored, and oSquashCount increments by 1 when FETCH_PERF_EN is defined.
- Sequential run through 10'h3FF: the next oPC is 10'h000; Reset asserted mid-stream gives oValid=0 and oPC=0 after that edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the araucaria instruction-fetch stage.
// Holds the default widths, the NOP encoding and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int DEF_PC_W    = 10;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OFF_W   = 6;

  // An all-zero instruction word is the architectural NOP; it is what a
  // squashed IF/ID slot carries.
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetchState_t;

endpackage

// File: rtl/fetch_stage_pc_target.sv
// pc_target: combinational redirect resolution for the fetch stage.
// A jump wins over a taken branch; the branch target is the PC after the
// branch plus the sign-extended offset, wrapping modulo 2^PC_W.
module pc_target #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6
) (
  input  logic            i_jmpEnable,
  input  logic [PC_W-1:0] i_jmpDir,
  input  logic            i_branchTaken,
  input  logic [PC_W-1:0] i_branchPc,
  input  logic [OFF_W-1:0] i_branchDir,
  output logic            o_redirect,
  output logic [PC_W-1:0] o_target
);

  localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] w_offExt;
  logic [PC_W-1:0] w_branchTarget;

  assign w_offExt       = {{(PC_W-OFF_W){i_branchDir[OFF_W-1]}}, i_branchDir};
  assign w_branchTarget = i_branchPc + PcOne + w_offExt;

  assign o_redirect = i_jmpEnable | i_branchTaken;
  assign o_target   = i_jmpEnable ? i_jmpDir : w_branchTarget;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the araucaria 5-stage pipeline.
// Owns the PC, drives the synchronous instruction ROM and presents the fetched
// instruction through a registered IF/ID boundary with a valid bit.
// Optional macro FETCH_PERF_EN adds the oFetchCount/oSquashCount counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OFF_W   = DEF_OFF_W
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [PC_W-1:0]    oRomAddr,
  input  logic [INSTR_W-1:0] iRomInstr,
  input  logic               iStall,
  input  logic               iJmpEnable,
  input  logic [PC_W-1:0]    iJmpDir,
  input  logic               iBranchTaken,
  input  logic [PC_W-1:0]    iBranchPC,
  input  logic [OFF_W-1:0]   iBranchDir,
  output logic [INSTR_W-1:0] oInstr,
  output logic [PC_W-1:0]    oPC,
  output logic               oValid,
  output logic               oKill
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        oFetchCount,
  output logic [7:0]         oSquashCount
`endif
);

  localparam logic [PC_W-1:0]    PcOne = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [INSTR_W-1:0] Nop   = INSTR_W'(NOP_INSTR);

  fetchState_t r_state;
  fetchState_t w_stateNext;

  logic [PC_W-1:0]    r_fpc;
  logic [PC_W-1:0]    r_reqPc;
  logic               r_reqValid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic               r_valid;

  logic [PC_W-1:0]    w_fpcNext;
  logic [PC_W-1:0]    w_reqPcNext;
  logic               w_reqValidNext;
  logic [INSTR_W-1:0] w_instrNext;
  logic [PC_W-1:0]    w_pcNext;
  logic               w_validNext;
  logic               w_load;

  logic               w_redirect;
  logic [PC_W-1:0]    w_target;

  pc_target #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pcTarget (
    .i_jmpEnable   (iJmpEnable),
    .i_jmpDir      (iJmpDir),
    .i_branchTaken (iBranchTaken),
    .i_branchPc    (iBranchPC),
    .i_branchDir   (iBranchDir),
    .o_redirect    (w_redirect),
    .o_target      (w_target)
  );

  // ROM address: a redirect fetches the target at once, a stall re-reads the
  // in-flight address so the ROM data stays put, otherwise fetch fpc.
  always_comb begin
    oRomAddr = r_fpc;
    if (Reset) begin
      oRomAddr = '0;
    end else if (w_redirect) begin
      oRomAddr = w_target;
    end else if (iStall) begin
      oRomAddr = r_reqPc;
    end
  end

  assign oKill  = w_redirect & ~Reset;
  assign oInstr = r_instr;
  assign oPC    = r_pc;
  assign oValid = r_valid;

  // Next-state and next-register values; a redirect overrides both stall and FSM state.
  always_comb begin
    w_stateNext    = r_state;
    w_fpcNext      = r_fpc;
    w_reqPcNext    = r_reqPc;
    w_reqValidNext = r_reqValid;
    w_instrNext    = r_instr;
    w_pcNext       = r_pc;
    w_validNext    = r_valid;
    w_load         = 1'b0;
    if (w_redirect) begin
      w_fpcNext      = w_target + PcOne;
      w_reqPcNext    = w_target;
      w_reqValidNext = 1'b1;
      w_instrNext    = Nop;
      w_validNext    = 1'b0;
      w_stateNext    = RUN;
    end else begin
      case (r_state)
        BOOT: begin
          w_reqPcNext    = r_fpc;
          w_fpcNext      = r_fpc + PcOne;
          w_reqValidNext = 1'b1;
          w_stateNext    = iStall ? HOLD : RUN;
        end
        RUN, HOLD: begin
          if (iStall) begin
            w_stateNext = HOLD;
          end else begin
            w_instrNext    = iRomInstr;
            w_pcNext       = r_reqPc;
            w_validNext    = r_reqValid;
            w_reqPcNext    = r_fpc;
            w_fpcNext      = r_fpc + PcOne;
            w_reqValidNext = 1'b1;
            w_load         = 1'b1;
            w_stateNext    = RUN;
          end
        end
        default: begin
          w_stateNext = BOOT;
        end
      endcase
    end
  end

  // FSM state register; reset drops any in-flight request or pending redirect.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // PC, in-flight request and IF/ID pipeline registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_fpc      <= '0;
      r_reqPc    <= '0;
      r_reqValid <= 1'b0;
      r_instr    <= Nop;
      r_pc       <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_fpc      <= w_fpcNext;
      r_reqPc    <= w_reqPcNext;
      r_reqValid <= w_reqValidNext;
      r_instr    <= w_instrNext;
      r_pc       <= w_pcNext;
      r_valid    <= w_validNext;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetchCount;
  logic [7:0]  r_squashCount;

  // Saturating counters of valid IF/ID loads and of redirects.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_fetchCount  <= '0;
      r_squashCount <= '0;
    end else begin
      if (w_load && r_reqValid && (r_fetchCount != 16'hFFFF)) begin
        r_fetchCount <= r_fetchCount + 16'd1;
      end
      if (w_redirect && (r_squashCount != 8'hFF)) begin
        r_squashCount <= r_squashCount + 8'd1;
      end
    end
  end

  assign oFetchCount  = r_fetchCount;
  assign oSquashCount = r_squashCount;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: testbench for fetch_stage with a ROM model holding 16'h1000+addr.
// Expected fetched PCs are queued by the stimulus; a monitor pops and compares
// every new valid IF/ID presentation.
module tb_fetch_stage;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  oRomAddr;
  logic [15:0] iRomInstr = 16'h0000;
  logic        iStall = 1'b0;
  logic        iJmpEnable = 1'b0;
  logic [9:0]  iJmpDir = '0;
  logic        iBranchTaken = 1'b0;
  logic [9:0]  iBranchPC = '0;
  logic [5:0]  iBranchDir = '0;
  logic [15:0] oInstr;
  logic [9:0]  oPC;
  logic        oValid;
  logic        oKill;
`ifdef FETCH_PERF_EN
  logic [15:0] oFetchCount;
  logic [7:0]  oSquashCount;
`endif

  int checkCount = 0;
  int errorCount = 0;
  logic [9:0] expQ[$];
  logic       monLoad;
  logic [9:0] monPc;

  fetch_stage dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oRomAddr     (oRomAddr),
    .iRomInstr    (iRomInstr),
    .iStall       (iStall),
    .iJmpEnable   (iJmpEnable),
    .iJmpDir      (iJmpDir),
    .iBranchTaken (iBranchTaken),
    .iBranchPC    (iBranchPC),
    .iBranchDir   (iBranchDir),
    .oInstr       (oInstr),
    .oPC          (oPC),
    .oValid       (oValid),
    .oKill        (oKill)
`ifdef FETCH_PERF_EN
    ,
    .oFetchCount  (oFetchCount),
    .oSquashCount (oSquashCount)
`endif
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM: data for the address sampled at the previous edge.
  always @(posedge Clock) iRomInstr <= 16'h1000 + {6'b0, oRomAddr};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic jmp, input logic [9:0] jmpDir,
                               input logic br, input logic [9:0] brPc, input logic [5:0] brDir);
    iStall       = stall;
    iJmpEnable   = jmp;
    iJmpDir      = jmpDir;
    iBranchTaken = br;
    iBranchPC    = brPc;
    iBranchDir   = brDir;
  endtask

  // Issue a one-cycle redirect, check kill/bubble, then expect n fetches from target.
  task automatic doRedirect(input string name, input logic stall, input logic jmp, input logic [9:0] jmpDir,
                            input logic br, input logic [9:0] brPc, input logic [5:0] brDir,
                            input logic [9:0] target, input int n);
    applyStimulus(stall, jmp, jmpDir, br, brPc, brDir);
    #1;
    checkOutput({name, "_kill_high"}, oKill, 1);
    checkOutput({name, "_rom_addr"}, oRomAddr, target);
    @(negedge Clock);
    applyStimulus(0, 0, '0, 0, '0, '0);
    #1;
    checkOutput({name, "_kill_low"}, oKill, 0);
    checkOutput({name, "_bubble_valid"}, oValid, 0);
    for (int i = 0; i < n; i++) expQ.push_back(target + 10'(i));
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: after every edge that loads IF/ID, a valid output must match the queue head.
  always @(posedge Clock) begin
    monLoad = !Reset && !iStall && !(iJmpEnable || iBranchTaken);
    #1;
    if (monLoad && oValid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL sb_unexpected: got pc 0x%0h, expected no fetch", oPC);
      end else begin
        monPc = expQ.pop_front();
        checkOutput("sb_pc", oPC, monPc);
        checkOutput("sb_instr", oInstr, 16'h1000 + {6'b0, monPc});
      end
    end
  end

  initial begin
    applyStimulus(0, 0, '0, 0, '0, '0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checkOutput("reset_pc", oPC, 0);
    checkOutput("reset_instr", oInstr, 16'h0000);
    checkOutput("reset_valid", oValid, 0);
    checkOutput("reset_kill", oKill, 0);
    checkOutput("reset_rom_addr", oRomAddr, 0);
`ifdef FETCH_PERF_EN
    checkOutput("reset_fetch_count", oFetchCount, 0);
    checkOutput("reset_squash_count", oSquashCount, 0);
`endif

    // Reset release: edge 0 issues address 0, edges 1..6 present PCs 0..5.
    for (int i = 0; i < 6; i++) expQ.push_back(10'(i));
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("boot_valid", oValid, 0);
    repeat (6) @(negedge Clock);
    checkOutput("run_pc5", oPC, 10'd5);

    // Three stalled cycles with PC 5 held in IF/ID.
    applyStimulus(1, 0, '0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checkOutput("stall_pc", oPC, 10'd5);
      checkOutput("stall_instr", oInstr, 16'h1005);
      checkOutput("stall_valid", oValid, 1);
    end
    applyStimulus(0, 0, '0, 0, '0, '0);
    for (int i = 6; i < 9; i++) expQ.push_back(10'(i));
    repeat (3) @(negedge Clock);

    doRedirect("jmp", 0, 1, 10'h200, 0, '0, '0, 10'h200, 2);
    doRedirect("branch", 0, 0, '0, 1, 10'h010, 6'b111100, 10'h00D, 2);
    doRedirect("combined", 1, 1, 10'h050, 1, 10'h01F, 6'b000000, 10'h050, 2);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetch_count", oFetchCount, 15);
    checkOutput("perf_squash_count", oSquashCount, 3);
`endif

    // Run across the top of the address space.
    doRedirect("wrap", 0, 1, 10'h3FD, 0, '0, '0, 10'h3FD, 5);
    checkOutput("wrap_pc", oPC, 10'h001);

    // Reset in the middle of the stream.
    Reset = 1'b1;
    @(negedge Clock);
    checkOutput("midreset_valid", oValid, 0);
    checkOutput("midreset_pc", oPC, 0);
    checkOutput("midreset_instr", oInstr, 16'h0000);
`ifdef FETCH_PERF_EN
    checkOutput("midreset_fetch_count", oFetchCount, 0);
`endif
    checkOutput("queue_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
